rggen_lock_key_controller: RTL and testbench



---
 rtl/rggen_lock_key_pkg.sv | 18 +
 rtl/rggen_lock_key_controller_if.sv | 12 +
 rtl/rggen_lock_key_timer.sv | 23 ++
 rtl/rggen_lock_key_controller.sv | 97 +++++++++
 tb/tb_rggen_lock_key_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rggen_lock_key_pkg.sv
// Shared types and constants for the lock-key controller.
package rggen_lock_key_pkg;

  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    KEY1_WAIT = 2'd1,
    UNLOCKED  = 2'd2,
    LOCKOUT   = 2'd3
  } lock_state_e;

  localparam logic [31:0] DEFAULT_KEY0 = 32'h0000_C0DE;
  localparam logic [31:0] DEFAULT_KEY1 = 32'h0000_FACE;

  function automatic int fail_cnt_w(int max_fails);
    return (max_fails < 1) ? 1 : $clog2(max_fails + 1);
  endfunction

endpackage

// File: rtl/rggen_lock_key_controller_if.sv
// Key-register bus command signals shared by the register block and the controller.
interface rggen_lock_key_controller_if #(
  parameter int WIDTH = 32
);
  logic             i_command_valid;
  logic             i_select;
  logic             i_write;
  logic [WIDTH-1:0] i_write_data;

  modport master (output i_command_valid, i_select, i_write, i_write_data);
  modport slave  (input  i_command_valid, i_select, i_write, i_write_data);
endinterface

// File: rtl/rggen_lock_key_timer.sv
// Unlock-window down-counter: loads on entry to UNLOCKED, expires on its last cycle.
module rggen_lock_key_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= CW'(CYCLES);
    else if (run && cnt != '0) cnt <= cnt - CW'(1);
  end

  // count==1 marks the final open cycle, giving exactly CYCLES cycles open
  assign expire = run && (cnt == CW'(1));
endmodule

// File: rtl/rggen_lock_key_controller.sv
// Two-word key sequence controller for rwl/rwe fields with bad-key lockout.
// Optional auto-relock timeout: define RGGEN_LOCK_KEY_TIMEOUT_EN.
module rggen_lock_key_controller
  import rggen_lock_key_pkg::*;
#(
  parameter int          WIDTH          = 32,
  parameter logic [31:0] KEY0           = DEFAULT_KEY0,
  parameter logic [31:0] KEY1           = DEFAULT_KEY1,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MAX_FAILS      = 3,
  localparam int         FCW            = fail_cnt_w(MAX_FAILS)
) (
  input  logic                        clk,
  input  logic                        rst,
  rggen_lock_key_controller_if.slave  bus,
  output logic                        o_lock,
  output logic                        o_enable,
  output logic                        o_error,
  output logic [FCW-1:0]              o_fail_count,
  output logic                        o_lockout
);
  localparam logic [WIDTH-1:0] K0   = WIDTH'(KEY0);
  localparam logic [WIDTH-1:0] K1   = WIDTH'(KEY1);
  localparam logic [FCW-1:0]   MAXV = FCW'(MAX_FAILS);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  lock_state_e    state, state_nxt;
  logic           key_wr, fail, expire;
  logic [FCW-1:0] fail_inc, fail_nxt;

  assign key_wr   = bus.i_command_valid & bus.i_select & bus.i_write;
  assign fail_inc = (o_fail_count == MAXV) ? o_fail_count : o_fail_count + FCW'(1);

`ifdef RGGEN_LOCK_KEY_TIMEOUT_EN
  logic t_load, t_run;
  assign t_load = (state != UNLOCKED) && (state_nxt == UNLOCKED);
  assign t_run  = (state == UNLOCKED);

  rggen_lock_key_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .run    (t_run),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOCKED;
      o_lock       <= 1'b1;
      o_enable     <= 1'b0;
      o_error      <= 1'b0;
      o_fail_count <= '0;
      o_lockout    <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_lock       <= (state_nxt != UNLOCKED);
      o_enable     <= (state_nxt == UNLOCKED);
      o_error      <= fail;
      o_fail_count <= fail_nxt;
      o_lockout    <= (state_nxt == LOCKOUT);
    end
  end

  always_comb begin
    state_nxt = state;
    fail      = 1'b0;
    fail_nxt  = o_fail_count;
    case (state)
      LOCKED: if (key_wr) begin
        if (bus.i_write_data == K0) state_nxt = KEY1_WAIT;
        else                        fail      = 1'b1;
      end
      KEY1_WAIT: if (key_wr) begin
        if (bus.i_write_data == K1) begin
          state_nxt = UNLOCKED;
          fail_nxt  = '0;
        end else begin
          fail = 1'b1;
        end
      end
      // relock write and expiry together still make one transition
      UNLOCKED: if (key_wr || expire) state_nxt = LOCKED;
      default:  state_nxt = LOCKOUT;
    endcase
    if (fail) begin
      fail_nxt  = fail_inc;
      state_nxt = (MAX_FAILS != 0 && fail_inc == MAXV) ? LOCKOUT : LOCKED;
    end
  end
endmodule

// File: tb/tb_rggen_lock_key_controller.sv
// Directed plus randomized bench with a behavioural key-sequence model.
module tb_rggen_lock_key_controller;
  localparam int WIDTH = 32;
  localparam int T     = 16;
  localparam int MAXF  = 3;
  localparam logic [31:0] K0 = 32'h0000_C0DE;
  localparam logic [31:0] K1 = 32'h0000_FACE;
`ifdef RGGEN_LOCK_KEY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       o_lock, o_enable, o_error, o_lockout;
  logic [1:0] o_fail_count;

  int checks   = 0;
  int failures = 0;

  // behavioural model: is the gate open, is the first key held, bad-key tally
  bit m_open, m_half, m_dead, m_err;
  int m_fails, m_left;

  rggen_lock_key_controller_if #(.WIDTH(WIDTH)) bus ();

  rggen_lock_key_controller #(
    .WIDTH(WIDTH), .KEY0(K0), .KEY1(K1), .TIMEOUT_CYCLES(T), .MAX_FAILS(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_lock(o_lock), .o_enable(o_enable), .o_error(o_error),
    .o_fail_count(o_fail_count), .o_lockout(o_lockout)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".lock"},   32'(o_lock),       32'(!m_open));
    check({tag, ".enable"}, 32'(o_enable),     32'(m_open));
    check({tag, ".error"},  32'(o_error),      32'(m_err));
    check({tag, ".fails"},  32'(o_fail_count), 32'(m_fails));
    check({tag, ".lockout"},32'(o_lockout),    32'(m_dead));
  endtask

  task automatic model_reset();
    m_open = 0; m_half = 0; m_dead = 0; m_err = 0; m_fails = 0; m_left = 0;
  endtask

  task automatic model_fail();
    m_err  = 1;
    m_half = 0;
    if (m_fails < MAXF) m_fails++;
    if (MAXF != 0 && m_fails == MAXF) m_dead = 1;
  endtask

  task automatic model_step(bit wr, logic [31:0] d);
    m_err = 0;
    if (m_dead) begin
    end else if (m_open) begin
      if (wr) m_open = 0;
      else if (TO_EN && m_left == 1) m_open = 0;
      else m_left--;
    end else if (m_half) begin
      if (wr) begin
        if (d == K1) begin m_open = 1; m_half = 0; m_fails = 0; m_left = T; end
        else model_fail();
      end
    end else if (wr) begin
      if (d == K0) m_half = 1;
      else model_fail();
    end
  endtask

  task automatic cyc(string tag, bit v, bit s, bit w, logic [31:0] d);
    bus.i_command_valid = v;
    bus.i_select        = s;
    bus.i_write         = w;
    bus.i_write_data    = d;
    @(posedge clk);
    model_step(v & s & w, d);
    #1;
    check_all(tag);
  endtask

  task automatic wr(string tag, logic [31:0] d); cyc(tag, 1, 1, 1, d); endtask
  task automatic idle(string tag);               cyc(tag, 0, 0, 0, 32'h0); endtask

  // asynchronous reset pulse asserted mid-cycle, checked before any clock edge
  task automatic async_reset(string tag);
    idle({tag, ".pre"});
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int hi;
    bus.i_command_valid = 0; bus.i_select = 0; bus.i_write = 0; bus.i_write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // basic unlock then relock with data 0
    wr("unlock.k0", K0);
    wr("unlock.k1", K1);
    check("unlock.enable_now", 32'(o_enable), 32'd1);
    wr("relock", 32'h0);
    check("relock.no_error", 32'(o_error), 32'd0);

    // reads and idle cycles do not abort a sequence
    wr("gap.k0", K0);
    cyc("gap.read", 1, 1, 0, K1);
    cyc("gap.unsel", 1, 0, 1, 32'h1234);
    repeat (5) idle("gap.idle");
    wr("gap.k1", K1);
    check("gap.enable", 32'(o_enable), 32'd1);
    wr("gap.relock", K0);

    // bad keys into lockout; correct keys then ignored
    wr("bad.k0", K0);
    wr("bad.1", 32'h1234);
    check("bad.error_pulse", 32'(o_error), 32'd1);
    idle("bad.pulse_end");
    wr("bad.2", K1);
    wr("bad.3k0", K0);
    wr("bad.3k0again", K0);
    check("bad.lockout", 32'(o_lockout), 32'd1);
    wr("dead.k0", K0);
    wr("dead.k1", K1);
    async_reset("rst_lockout");
    wr("fresh.k0", K0);
    wr("fresh.k1", K1);

    // auto-relock window, counted from the unlocking write
    hi = 1;
    for (int i = 0; i < 40 && o_enable; i++) begin
      idle("timeout.idle");
      if (o_enable) hi++;
    end
    if (TO_EN) check("timeout.open_cycles", 32'(hi), 32'(T));
    else       check("timeout.still_open", 32'(o_enable), 32'd1);
    if (!TO_EN) begin
      repeat (80) idle("noto.idle");
      check("noto.open_100", 32'(o_enable), 32'd1);
      wr("noto.relock", 32'h0);
    end

    // relock write landing on the expiry cycle
    wr("coinc.k0", K0);
    wr("coinc.k1", K1);
    repeat (T - 1) idle("coinc.idle");
    wr("coinc.relock", 32'hDEAD);
    check("coinc.locked", 32'(o_lock), 32'd1);
    idle("coinc.after");

    // reset while holding the first key
    wr("k1wait.k0", K0);
    async_reset("rst_k1wait");
    wr("k1wait.k1_alone", K1);
    wr("k1wait.fresh_k0", K0);
    wr("k1wait.fresh_k1", K1);
    check("k1wait.unlock", 32'(o_enable), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: d = K0;
        1: d = K1;
        2: d = 32'h0;
        default: d = $urandom;
      endcase
      cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0, d);
      if (i % 97 == 96) async_reset("rand.rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
